// File: rtl/axis_mem_stream_tester.sv
// axis_mem_stream_tester
//   Self-checking AXI-Stream source/sink for exercising a stream memory path.
//   A test writes BURST_LEN pattern words (seed + i) out of the m00 port, then
//   accepts BURST_LEN readback beats on the s00 port and checks each one for
//   data, strobes and tlast. The result is reported as pass / err_count /
//   timeout_err with a one-cycle done pulse.
//
// Ports
//   axis_aclk, axis_areset : clock, synchronous active-high reset
//   start, seed            : launch pulse (honoured only in IDLE), pattern base
//   busy, done             : test in progress, one-cycle end-of-test pulse
//   pass, err_count,
//   timeout_err            : results, held until the next accepted start
//   m00_axis_*             : write-burst master stream
//   s00_axis_*             : readback slave stream
//   dbg_state              : current FSM state (0 IDLE, 1 WRITE, 2 READ, 3 DONE)
//
// Handshake: a beat transfers on the rising edge where tvalid and tready are
// both high. The master holds tdata/tlast/tvalid stable until that edge; the
// slave side raises tready only while in READ.
module axis_mem_stream_tester #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 12,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    axis_aclk,
  input  logic                    axis_areset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic                    timeout_err,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tvalid,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  output logic [1:0]              dbg_state
);

  localparam int SW     = DATA_WIDTH / 8;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] ERR_MAX    = '1;
  localparam logic [IDLE_W-1:0]    IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [CNT_WIDTH-1:0]  idx_q;
  logic [IDLE_W-1:0]     idle_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic [CNT_WIDTH-1:0]  err_q;
  logic                  to_q;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic                  m_tvalid_q;
  logic                  m_tlast_q;
  logic                  s_tready_q;

  // Readback check for the beat currently offered on s00.
  logic [DATA_WIDTH-1:0] exp_word_d;
  logic [1:0]            miss_d;
  logic [CNT_WIDTH+1:0]  err_sum_d;
  logic [CNT_WIDTH-1:0]  err_d;

  always_comb begin
    exp_word_d = seed_q + DATA_WIDTH'(idx_q);
    miss_d     = 2'(s00_axis_tdata != exp_word_d)
               + 2'(s00_axis_tstrb != {SW{1'b1}})
               + 2'(s00_axis_tlast != (idx_q == LAST_IDX));
    err_sum_d  = {2'b00, err_q} + (CNT_WIDTH + 2)'(miss_d);
    // A beat can add up to three errors, so saturate on the widened sum.
    err_d      = (err_sum_d > {2'b00, ERR_MAX}) ? ERR_MAX : err_sum_d[CNT_WIDTH-1:0];
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q    <= S_IDLE;
      seed_q     <= '0;
      idx_q      <= '0;
      idle_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      to_q       <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      s_tready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            seed_q     <= seed;
            err_q      <= '0;
            pass_q     <= 1'b0;
            to_q       <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= seed;
            m_tlast_q  <= (BURST_LEN == 1);
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          // tvalid is high for the whole of WRITE, so tready alone marks a transfer.
          if (m00_axis_tready) begin
            if (idx_q == LAST_IDX) begin
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              idx_q      <= '0;
              idle_q     <= '0;
              s_tready_q <= 1'b1;
              state_q    <= S_READ;
            end else begin
              idx_q     <= idx_q + CNT_WIDTH'(1);
              m_tdata_q <= m_tdata_q + DATA_WIDTH'(1);
              m_tlast_q <= ((idx_q + CNT_WIDTH'(1)) == LAST_IDX);
            end
          end
        end
        S_READ: begin
          if (s00_axis_tvalid) begin
            err_q  <= err_d;
            idle_q <= '0;
            // Only the beat count ends the read; an early tlast is just an error.
            if (idx_q == LAST_IDX) begin
              idx_q      <= '0;
              s_tready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              pass_q     <= (err_d == '0);
              state_q    <= S_DONE;
            end else begin
              idx_q <= idx_q + CNT_WIDTH'(1);
            end
          end else if (idle_q == IDLE_LIMIT) begin
            to_q       <= 1'b1;
            s_tready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            pass_q     <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign timeout_err     = to_q;
  assign m00_axis_tdata  = m_tdata_q;
  assign m00_axis_tstrb  = {SW{1'b1}};
  assign m00_axis_tvalid = m_tvalid_q;
  assign m00_axis_tlast  = m_tlast_q;
  assign s00_axis_tready = s_tready_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_axis_mem_stream_tester.sv
// Directed testbench for axis_mem_stream_tester. Inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_axis_mem_stream_tester;

  localparam int DW = 32;
  localparam int BL = 16;
  localparam int CW = 12;
  localparam int TO = 1024;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // DUT signals
  logic          start;
  logic [DW-1:0] seed;
  logic          busy, done, pass, timeout_err;
  logic [CW-1:0] err_count;
  logic [DW-1:0] m_tdata;
  logic [3:0]    m_tstrb;
  logic          m_tvalid, m_tlast, m_tready;
  logic [DW-1:0] s_tdata;
  logic [3:0]    s_tstrb;
  logic          s_tvalid, s_tlast, s_tready;
  logic [1:0]    dbg_state;

  axis_mem_stream_tester #(
    .DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .axis_aclk       (clk),
    .axis_areset     (rst),
    .start           (start),
    .seed            (seed),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .timeout_err     (timeout_err),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .dbg_state       (dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Per-beat readback corruption table.
  logic [DW-1:0] rx_xor  [BL];
  logic [3:0]    rx_strb [BL];
  logic          rx_last [BL];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clean_readback();
    for (int i = 0; i < BL; i++) begin
      rx_xor[i]  = '0;
      rx_strb[i] = 4'hF;
      rx_last[i] = (i == BL - 1);
    end
  endtask

  // Pulse start; returns 1 ns after the edge that sampled it.
  task automatic do_start(input logic [DW-1:0] sd, output int start_edge);
    start = 1'b1;
    seed  = sd;
    step();
    start_edge = edges;
    start = 1'b0;
    seed  = 32'hA5A5_A5A5;
    chk("start_busy",  64'(busy), 64'd1);
    chk("start_valid", 64'(m_tvalid), 64'd1);
    chk("start_data",  64'(m_tdata), 64'(sd));
    chk("start_state", 64'(dbg_state), 64'd1);
  endtask

  // Consume the write burst, checking every transferred word and that
  // stalled words stay put. Junk is offered on s00 to show it is refused.
  task automatic run_write(input logic [DW-1:0] sd, input bit bp);
    int k = 0;
    int cyc = 0;
    bit phase = 1'b1;
    bit stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] w;
    s_tvalid = 1'b1;
    s_tdata  = 32'hDEAD_BEEF;
    while (k < BL && cyc < 200) begin
      chk("w_valid", 64'(m_tvalid), 64'd1);
      chk("w_s_ready_low", 64'(s_tready), 64'd0);
      if (stalled) chk("w_hold_data", 64'(m_tdata), 64'(held));
      m_tready = bp ? phase : 1'b1;
      phase = ~phase;
      if (m_tready) begin
        w = sd + 32'(k);
        chk("w_data", 64'(m_tdata), 64'(w));
        chk("w_last", 64'(m_tlast), 64'(k == BL - 1));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = m_tdata;
      end
      step();
      cyc++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    chk("w_count", 64'(k), 64'(BL));
    chk("w_cycles", 64'(cyc), bp ? 64'(2 * BL - 1) : 64'(BL));
    chk("w_end_valid", 64'(m_tvalid), 64'd0);
    chk("r_ready", 64'(s_tready), 64'd1);
  endtask

  // Offer n readback beats built from the corruption table.
  task automatic run_read(input logic [DW-1:0] sd, input int n);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 300) begin
      if (s_tready) begin
        s_tvalid = 1'b1;
        s_tdata  = (sd + 32'(k)) ^ rx_xor[k];
        s_tstrb  = rx_strb[k];
        s_tlast  = rx_last[k];
        k++;
      end else begin
        s_tvalid = 1'b0;
      end
      step();
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("r_count", 64'(k), 64'(n));
  endtask

  task automatic check_result(input string tag, input bit exp_pass,
                              input int exp_err, input bit exp_to);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'(exp_pass));
    chk({tag, "_err"},  64'(err_count), 64'(exp_err));
    chk({tag, "_to"},   64'(timeout_err), 64'(exp_to));
    chk({tag, "_rdy"},  64'(s_tready), 64'd0);
    step();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(dbg_state), 64'd0);
    chk({tag, "_pass_hold"}, 64'(pass), 64'(exp_pass));
    chk({tag, "_err_hold"},  64'(err_count), 64'(exp_err));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_pass"},  64'(pass), 64'd0);
    chk({tag, "_to"},    64'(timeout_err), 64'd0);
    chk({tag, "_err"},   64'(err_count), 64'd0);
    chk({tag, "_mvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_mlast"}, 64'(m_tlast), 64'd0);
    chk({tag, "_mdata"}, 64'(m_tdata), 64'd0);
    chk({tag, "_mstrb"}, 64'(m_tstrb), 64'hF);
    chk({tag, "_sready"}, 64'(s_tready), 64'd0);
  endtask

  initial begin
    int se;
    int c;
    rst = 1'b1; start = 1'b0; seed = '0; m_tready = 1'b0;
    s_tdata = '0; s_tstrb = 4'hF; s_tvalid = 1'b0; s_tlast = 1'b0;
    clean_readback();
    repeat (3) step();
    check_reset_values("rst");
    rst = 1'b0;
    step();

    // Loopback, no backpressure, seed 0x100.
    do_start(32'h100, se);
    run_write(32'h100, 1'b0);
    run_read(32'h100, BL);
    chk("t1_latency", 64'(edges - se), 64'(2 * BL));
    check_result("t1", 1'b1, 0, 1'b0);

    // Write backpressure: tready toggles 1,0.
    do_start(32'h2000, se);
    run_write(32'h2000, 1'b1);
    run_read(32'h2000, BL);
    check_result("t2", 1'b1, 0, 1'b0);

    // Data corrupted on beats 3 and 9, short strobe on beat 5.
    clean_readback();
    rx_xor[3] = 32'h1; rx_xor[9] = 32'h1; rx_strb[5] = 4'h7;
    do_start(32'h3000, se);
    run_write(32'h3000, 1'b0);
    run_read(32'h3000, BL);
    check_result("t3", 1'b0, 3, 1'b0);

    // tlast early on beat 7 and missing on beat 15; read still runs 16 beats.
    clean_readback();
    rx_last[7] = 1'b1; rx_last[15] = 1'b0;
    do_start(32'h4000, se);
    run_write(32'h4000, 1'b0);
    run_read(32'h4000, BL);
    check_result("t4", 1'b0, 2, 1'b0);

    // Readback stops after 10 beats; start during the stall must be ignored.
    clean_readback();
    do_start(32'h5000, se);
    run_write(32'h5000, 1'b0);
    run_read(32'h5000, 10);
    c = 0;
    while (!done && c < 1100) begin
      start = (c == 100);
      seed  = 32'h7777;
      step();
      c++;
    end
    start = 1'b0;
    chk("t5_timeout_cycles", 64'(c), 64'(TO));
    check_result("t5", 1'b0, 0, 1'b1);
    chk("t5_stay_idle", 64'(dbg_state), 64'd0);

    // Reset during WRITE.
    do_start(32'h55, se);
    m_tready = 1'b1;
    step();
    step();
    m_tready = 1'b0;
    rst = 1'b1;
    step();
    check_reset_values("mid_rst");
    rst = 1'b0;
    step();
    chk("mid_rst_no_done", 64'(done), 64'd0);

    // Pattern wrap-around.
    clean_readback();
    do_start(32'hFFFF_FFFE, se);
    run_write(32'hFFFF_FFFE, 1'b0);
    run_read(32'hFFFF_FFFE, BL);
    check_result("t6", 1'b1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
